// File: rtl/mmio_write_arbiter_pkg.sv
// Shared types and defaults for the MMIO write arbiter slice.
package lasd_pkg;
  localparam int unsigned ADDR_W_DEF    = 15;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned BURST_W       = 3;
  localparam logic [ADDR_W_DEF-1:0] IO_BASE_DEF = 15'h7FFE;

  typedef enum logic [1:0] {IDLE, WR, ACK} state_e;
endpackage

// File: rtl/mmio_write_arbiter_if.sv
// Two-port write request bundle plus RAM and parallel-output pins.
interface mmio_write_arbiter_if #(
  parameter int unsigned ADDR_W = lasd_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = lasd_pkg::DATA_W_DEF
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_out2;

  modport master (
    output req, addr0, data0, addr1, data1,
    input  gnt, done, ram_addr, ram_data, ram_wren, data_out, data_out2
  );
  modport slave (
    input  req, addr0, data0, addr1, data1,
    output gnt, done, ram_addr, ram_data, ram_wren, data_out, data_out2
  );
endinterface

// File: rtl/mmio_write_arbiter_rr_pick2.sv
// Combinational winner selection with a per-port burst limit.
module rr_pick2
  import lasd_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic [1:0]         req,
  input  logic               last,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               win,
  output logic [BURST_W-1:0] burst_nxt
);
  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  // burst_cnt==0 only before the first grant: the other port (port 0, as
  // last resets to 1) then has priority, so port 0 wins the first tie.
  always_comb begin
    win       = last;
    burst_nxt = BURST_W'(1);
    if (req[last] && (burst_cnt != '0) && (burst_cnt < MAX_B)) begin
      burst_nxt = burst_cnt + BURST_W'(1);
    end else if (req[~last]) begin
      win = ~last;
    end
  end
endmodule

// File: rtl/mmio_write_arbiter.sv
// Arbitrates two write requesters onto the RAM write port and two IO registers.
module mmio_write_arbiter
  import lasd_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] IO_BASE   = IO_BASE_DEF,
  parameter int unsigned       MAX_BURST = MAX_BURST_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  mmio_write_arbiter_if.slave bus
);
  state_e             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_data_q, ram_data_d;
  logic               ram_wren_q, ram_wren_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic [DATA_W-1:0]  data_out2_q, data_out2_d;
  logic               last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic               win;
  logic [BURST_W-1:0] burst_nxt;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               io_hit;

  rr_pick2 #(.MAX_BURST(MAX_BURST)) u_pick (
    .req       (bus.req),
    .last      (last_q),
    .burst_cnt (burst_q),
    .win       (win),
    .burst_nxt (burst_nxt)
  );

  assign sel_addr = win ? bus.addr1 : bus.addr0;
  assign sel_data = win ? bus.data1 : bus.data0;
  assign io_hit   = (sel_addr[ADDR_W-1:1] == IO_BASE[ADDR_W-1:1]);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_wren_d  = ram_wren_q;
    data_out_d  = data_out_q;
    data_out2_d = data_out2_q;
    last_d      = last_q;
    burst_d     = burst_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          ram_addr_d = sel_addr;
          ram_data_d = sel_data;
          last_d     = win;
          burst_d    = burst_nxt;
          if (io_hit) begin
            if (sel_addr[0]) data_out_d  = sel_data;
            else             data_out2_d = sel_data;
            ram_wren_d = 1'b0;
          end else begin
            ram_wren_d = 1'b1;
          end
          state_d = WR;
        end
      end
      WR: begin
        ram_wren_d = 1'b0;
        done_d     = gnt_q;
        state_d    = ACK;
      end
      ACK: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      data_out_q  <= '0;
      data_out2_q <= '0;
      last_q      <= 1'b1;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wren_q  <= ram_wren_d;
      data_out_q  <= data_out_d;
      data_out2_q <= data_out2_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_wren  = ram_wren_q;
  assign bus.data_out  = data_out_q;
  assign bus.data_out2 = data_out2_q;
endmodule
